// File: rtl/psdsqrt_sched.sv
// Sequencer and 2-way round-robin arbiter sharing one psdsqrt unit between two requesters.
// Optional op_count output is enabled by defining PSDSQRT_SCHED_OPCNT_EN.
module psdsqrt_sched #(
   parameter int CALC_CYCLES = 16,
   parameter int XW          = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req0,
   input  logic [XW-1:0]     x0,
   output logic              ack0,
   input  logic              req1,
   input  logic [XW-1:0]     x1,
   output logic              ack1,
   output logic              res_valid,
   output logic              res_id,
   output logic [XW/2-1:0]   res_data,
   input  logic              res_ack,
   output logic              busy,
   output logic              sqrt_start,
   output logic              sqrt_stop,
   output logic [XW-1:0]     sqrt_xin,
   input  logic [XW/2-1:0]   sqrt_in
`ifdef PSDSQRT_SCHED_OPCNT_EN
   ,
   output logic [15:0]       op_count
`endif
);

   // state  | meaning
   // IDLE   | waiting for a request; grant and operand latch happen here
   // START  | sqrt_start pulse, wait counter loaded
   // WAIT   | CALC_CYCLES cycles of unit iteration
   // STOP   | sqrt_stop pulse
   // CAPT   | root captured from the unit
   // RESP   | result presented until res_ack

   localparam int RW = XW / 2;
   localparam int CW = (CALC_CYCLES > 1) ? $clog2(CALC_CYCLES) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_WAIT, S_STOP, S_CAPT, S_RESP
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [XW-1:0] xin_q, xin_d;
   logic          id_q, id_d;
   logic          rr_ptr_q, rr_ptr_d;
   logic          res_id_q, res_id_d;
   logic [RW-1:0] res_data_q, res_data_d;
   logic          grant;

`ifdef PSDSQRT_SCHED_OPCNT_EN
   logic [15:0]   op_count_q, op_count_d;
`endif

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      xin_d      = xin_q;
      id_d       = id_q;
      rr_ptr_d   = rr_ptr_q;
      res_id_d   = res_id_q;
      res_data_d = res_data_q;
      grant      = 1'b0;
      ack0       = 1'b0;
      ack1       = 1'b0;
      sqrt_start = 1'b0;
      sqrt_stop  = 1'b0;
`ifdef PSDSQRT_SCHED_OPCNT_EN
      op_count_d = op_count_q;
`endif
      case (state_q)
         S_IDLE: begin
            // rr_ptr holds the requester that wins a tie; it flips away from whoever is served
            if (!reset && (req0 || req1)) begin
               grant    = (req0 && req1) ? rr_ptr_q : req1;
               ack0     = ~grant;
               ack1     = grant;
               xin_d    = grant ? x1 : x0;
               id_d     = grant;
               rr_ptr_d = ~grant;
               state_d  = S_START;
            end
         end
         S_START: begin
            sqrt_start = 1'b1;
            cnt_d      = CW'(CALC_CYCLES - 1);
            state_d    = S_WAIT;
         end
         S_WAIT: begin
            if (cnt_q == '0) begin
               state_d = S_STOP;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_STOP: begin
            sqrt_stop = 1'b1;
            state_d   = S_CAPT;
         end
         S_CAPT: begin
            res_data_d = sqrt_in;
            res_id_d   = id_q;
            state_d    = S_RESP;
         end
         S_RESP: begin
            if (res_ack) begin
               state_d = S_IDLE;
`ifdef PSDSQRT_SCHED_OPCNT_EN
               op_count_d = op_count_q + 16'd1;
`endif
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         xin_q      <= '0;
         id_q       <= 1'b0;
         rr_ptr_q   <= 1'b0;
         res_id_q   <= 1'b0;
         res_data_q <= '0;
`ifdef PSDSQRT_SCHED_OPCNT_EN
         op_count_q <= '0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         xin_q      <= xin_d;
         id_q       <= id_d;
         rr_ptr_q   <= rr_ptr_d;
         res_id_q   <= res_id_d;
         res_data_q <= res_data_d;
`ifdef PSDSQRT_SCHED_OPCNT_EN
         op_count_q <= op_count_d;
`endif
      end
   end

   assign sqrt_xin  = xin_q;
   assign res_data  = res_data_q;
   assign res_id    = res_id_q;
   assign busy      = (state_q != S_IDLE);
   assign res_valid = (state_q == S_RESP);
`ifdef PSDSQRT_SCHED_OPCNT_EN
   assign op_count  = op_count_q;
`endif

endmodule

// File: tb/tb_psdsqrt_sched.sv
// Self-checking bench for psdsqrt_sched: transaction-level model plus directed and random stimulus.
module tb_psdsqrt_sched;

   localparam int CALC = 16;
   localparam int XW   = 32;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        req0 = 1'b0, req1 = 1'b0;
   logic [31:0] x0 = '0, x1 = '0;
   logic        ack0, ack1;
   logic        res_valid, res_id;
   logic [15:0] res_data;
   logic        res_ack = 1'b0;
   logic        busy, sqrt_start, sqrt_stop;
   logic [31:0] sqrt_xin;
   logic [15:0] sqrt_in = '0;
`ifdef PSDSQRT_SCHED_OPCNT_EN
   logic [15:0] op_count;
`endif

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   psdsqrt_sched #(.CALC_CYCLES(CALC), .XW(XW)) dut (
      .clock(clock), .reset(reset),
      .req0(req0), .x0(x0), .ack0(ack0),
      .req1(req1), .x1(x1), .ack1(ack1),
      .res_valid(res_valid), .res_id(res_id), .res_data(res_data), .res_ack(res_ack),
      .busy(busy), .sqrt_start(sqrt_start), .sqrt_stop(sqrt_stop),
      .sqrt_xin(sqrt_xin), .sqrt_in(sqrt_in)
`ifdef PSDSQRT_SCHED_OPCNT_EN
      , .op_count(op_count)
`endif
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // golden bit-serial integer square root
   function automatic logic [15:0] isqrt(input logic [31:0] x);
      longint unsigned op, res, one;
      op  = x;
      res = 0;
      one = 64'd1 << 30;
      while (one > op) one = one >> 2;
      while (one != 0) begin
         if (op >= res + one) begin
            op  = op - (res + one);
            res = (res >> 1) + one;
         end else begin
            res = res >> 1;
         end
         one = one >> 2;
      end
      return res[15:0];
   endfunction

   // psdsqrt stand-in: output is garbage during the computation, valid after stop
   always @(posedge clock) begin
      if (sqrt_start)     sqrt_in <= 16'($urandom);
      else if (sqrt_stop) sqrt_in <= isqrt(sqrt_xin);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   // transaction-level model: cycles elapsed since the grant define every phase
   bit          m_busy = 0;
   int          m_t = 0;
   bit          m_id = 0;
   int          m_last = -1;
   logic [31:0] m_xin = '0;
   logic [15:0] m_data = '0;
   bit          m_rid = 0;
   int          m_ops = 0;

   always @(negedge clock) begin
      int g;
      bit any;
      any = !reset && !m_busy && (req0 || req1);
      if (req0 && req1) g = (m_last == 0) ? 1 : 0;
      else              g = req1 ? 1 : 0;
      chk("ack0",       ack0,       any && g == 0);
      chk("ack1",       ack1,       any && g == 1);
      chk("busy",       busy,       m_busy);
      chk("sqrt_start", sqrt_start, m_busy && m_t == 1);
      chk("sqrt_stop",  sqrt_stop,  m_busy && m_t == CALC + 2);
      chk("res_valid",  res_valid,  m_busy && m_t >= CALC + 4);
      chk("res_data",   res_data,   m_data);
      chk("res_id",     res_id,     m_rid);
      chk("sqrt_xin",   sqrt_xin,   m_xin);
`ifdef PSDSQRT_SCHED_OPCNT_EN
      chk("op_count",   op_count,   m_ops & 32'hFFFF);
`endif
      if (reset) begin
         m_busy = 0; m_t = 0; m_id = 0; m_last = -1;
         m_xin = '0; m_data = '0; m_rid = 0; m_ops = 0;
      end else if (!m_busy) begin
         if (any) begin
            m_busy = 1; m_t = 1; m_id = g[0]; m_last = g;
            m_xin  = g ? x1 : x0;
         end
      end else begin
         if (m_t == CALC + 3) begin
            m_data = isqrt(m_xin);
            m_rid  = m_id;
         end
         if (m_t >= CALC + 4 && res_ack) begin
            m_busy = 0;
            m_ops++;
         end else begin
            m_t++;
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // one full operation; caller is just after a posedge
   task automatic do_op(input bit id, input logic [31:0] x, input int hold,
                        input logic [15:0] exp, input string nm);
      if (id) begin req1 = 1'b1; x1 = x; end
      else    begin req0 = 1'b1; x0 = x; end
      for (int k = 0; k < 50; k++) begin
         @(negedge clock);
         if (id ? ack1 : ack0) break;
      end
      chk({nm, "_ack"}, id ? ack1 : ack0, 1);
      tick();
      if (id) req1 = 1'b0; else req0 = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clock);
         if (res_valid) break;
      end
      chk({nm, "_valid"}, res_valid, 1);
      chk({nm, "_data"},  res_data, exp);
      chk({nm, "_id"},    res_id, id);
      repeat (hold) tick();
      tick();
      res_ack = 1'b1;
      tick();
      res_ack = 1'b0;
   endtask

   function automatic logic [31:0] rand_operand();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return 32'd65536;
         3: return 32'd65535;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int t_ack, t_start, t_stop, t_valid;
      int grants[4];
      int ng;
      bit a0, a1;

      // model pins
      chk("gold_0",    isqrt(32'd0), 0);
      chk("gold_max",  isqrt(32'hFFFF_FFFF), 65535);
      chk("gold_64k",  isqrt(32'd65536), 256);
      chk("gold_64km", isqrt(32'd65535), 255);
      chk("gold_t1",   isqrt(32'd123456), 351);
      chk("gold_144",  isqrt(32'd144), 12);

      repeat (2) tick();
      reset = 1'b0;
      @(negedge clock);
      chk("rst_busy",  busy, 0);
      chk("rst_valid", res_valid, 0);
      chk("rst_xin",   sqrt_xin, 0);
      chk("rst_data",  res_data, 0);

      // T1 single op with literal timing
      tick();
      req0 = 1'b1; x0 = 32'd123456;
      t_ack = -1000; t_start = -1000; t_stop = -1000; t_valid = -1000;
      @(negedge clock);
      chk("t1_ack0", ack0, 1);
      t_ack = cyc;
      tick();
      req0 = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clock);
         if (sqrt_start) t_start = cyc;
         if (sqrt_stop)  t_stop  = cyc;
         if (res_valid) begin t_valid = cyc; break; end
      end
      chk("t1_stop_gap", t_stop - t_start, 17);
      chk("t1_latency",  t_valid - t_ack, 20);
      chk("t1_data",     res_data, 351);
      chk("t1_id",       res_id, 0);
      tick();
      res_ack = 1'b1;
      tick();
      res_ack = 1'b0;

      // T2 corner operands
      do_op(1'b0, 32'd0,          0, 16'd0,     "t2_zero");
      do_op(1'b1, 32'hFFFF_FFFF,  2, 16'd65535, "t2_max");
      do_op(1'b0, 32'd65536,      0, 16'd256,   "t2_64k");
      do_op(1'b1, 32'd65535,      1, 16'd255,   "t2_64km");

      // T3 arbitration from fresh reset
      reset = 1'b1;
      tick();
      reset = 1'b0;
      req0 = 1'b1; x0 = 32'd100;
      req1 = 1'b1; x1 = 32'd400;
      res_ack = 1'b1;
      ng = 0;
      for (int k = 0; k < 200 && ng < 4; k++) begin
         @(negedge clock);
         if (ack0) begin grants[ng] = 0; ng++; end
         else if (ack1) begin grants[ng] = 1; ng++; end
      end
      chk("t3_ngrants", ng, 4);
      for (int i = 0; i < 4; i++) chk("t3_grant", (i < ng) ? grants[i] : -1, i % 2);
      tick();
      req0 = 1'b0; req1 = 1'b0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clock);
         if (!busy) break;
      end
      chk("t3_drain", busy, 0);
      tick();
      res_ack = 1'b0;

      // T4 backpressure with a competing request pending
      req0 = 1'b1; x0 = 32'd1000000;
      for (int k = 0; k < 50; k++) begin
         @(negedge clock);
         if (ack0) break;
      end
      tick();
      req0 = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clock);
         if (res_valid) break;
      end
      tick();
      req1 = 1'b1; x1 = 32'd5;
      for (int k = 0; k < 7; k++) begin
         @(negedge clock);
         chk("t4_valid", res_valid, 1);
         chk("t4_data",  res_data, 1000);
         chk("t4_id",    res_id, 0);
         chk("t4_quiet", {ack0, ack1, sqrt_start}, 0);
         tick();
      end
      res_ack = 1'b1;
      tick();
      res_ack = 1'b0;
      @(negedge clock);
      chk("t4_next_ack1", ack1, 1);
      tick();
      req1 = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clock);
         if (res_valid) break;
      end
      chk("t4_second", res_data, 2);
      tick();
      res_ack = 1'b1;
      tick();
      res_ack = 1'b0;

      // T5 reset in WAIT
      req0 = 1'b1; x0 = 32'd777777;
      for (int k = 0; k < 50; k++) begin
         @(negedge clock);
         if (ack0) break;
      end
      tick();
      req0 = 1'b0;
      repeat (3) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clock);
      chk("t5_outs", {ack0, ack1, res_valid, res_id, busy, sqrt_start, sqrt_stop}, 0);
      chk("t5_data", res_data, 0);
      chk("t5_xin",  sqrt_xin, 0);
      tick();
      do_op(1'b1, 32'd144, 0, 16'd12, "t5_op");

`ifdef PSDSQRT_SCHED_OPCNT_EN
      // T6 op counter
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 5; i++) do_op(i[0], 32'd49, 0, 16'd7, "t6_op");
      @(negedge clock);
      chk("t6_count5", op_count, 5);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clock);
      chk("t6_count0", op_count, 0);
      tick();
`endif

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         @(negedge clock);
         a0 = ack0;
         a1 = ack1;
         tick();
         if (req0) begin
            if (a0 && $urandom_range(0, 1) == 0) req0 = 1'b0;
         end else if ($urandom_range(0, 3) == 0) begin
            req0 = 1'b1; x0 = rand_operand();
         end
         if (req1) begin
            if (a1 && $urandom_range(0, 1) == 0) req1 = 1'b0;
         end else if ($urandom_range(0, 3) == 0) begin
            req1 = 1'b1; x1 = rand_operand();
         end
         res_ack = ($urandom_range(0, 2) == 0);
         reset   = ($urandom_range(0, 499) == 0);
      end
      reset = 1'b0;
      req0 = 1'b0; req1 = 1'b0;
      res_ack = 1'b1;
      for (int k = 0; k < 60; k++) begin
         @(negedge clock);
         if (!busy) break;
      end
      chk("final_drain", busy, 0);
      tick();
      res_ack = 1'b0;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
